// File: rtl/text_term.sv
// text_term: character-cell text terminal.
// It turns an incoming byte stream (printable characters plus CR, LF, BS and FF)
// into a COLS x LINES cell RAM. A separate registered read port serves the display.
// Ports:
//   clk_i, rst_i                 pixel clock, synchronous active-high reset
//   char_i, attr_i, char_valid_i byte stream in, attr = {fg[3:0], bg[3:0]}
//   char_ready_o                 a byte is accepted this cycle (IDLE only)
//   rd_col_i, rd_lin_i           display read address (text column/line)
//   chr_o, rgbifront_o, rgbiback_o  read cell contents, one cycle after the address
//   cursor_col_o, cursor_lin_o   current cursor position
//   busy_o                       high while a full-screen clear sweep runs
module text_term #(
    parameter int unsigned COLS       = 30,
    parameter int unsigned LINES      = 17,
    parameter logic [7:0]  CLEAR_ATTR = 8'h07
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] char_i,
    input  logic [7:0] attr_i,
    input  logic       char_valid_i,
    output logic       char_ready_o,
    input  logic [4:0] rd_col_i,
    input  logic [4:0] rd_lin_i,
    output logic [7:0] chr_o,
    output logic [3:0] rgbifront_o,
    output logic [3:0] rgbiback_o,
    output logic [4:0] cursor_col_o,
    output logic [4:0] cursor_lin_o,
    output logic       busy_o
);

    localparam int unsigned CW    = 5;
    localparam int unsigned LW    = 5;
    localparam int unsigned AW    = CW + LW;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [LW-1:0] LIN_LAST = LW'(LINES - 1);

    localparam logic [7:0] CHR_BLANK = 8'h20;
    localparam logic [7:0] CHR_TILDE = 8'h7E;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_CLRLINE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cur_col_q, cur_col_d;
    logic [LW-1:0] cur_lin_q, cur_lin_d;
    logic [CW-1:0] swp_col_q, swp_col_d;
    logic [LW-1:0] swp_lin_q, swp_lin_d;
    logic          ready_q;
    logic          busy_q;
    logic [DW-1:0] rd_data_q;

    logic [DW-1:0] mem [DEPTH];

    logic          accept_c;
    logic          advance_c;
    logic          we_c;
    logic [AW-1:0] waddr_c;
    logic [DW-1:0] wdata_c;

    // Next-state, cursor, sweep and write-port decode
    always_comb begin
        state_d   = state_q;
        cur_col_d = cur_col_q;
        cur_lin_d = cur_lin_q;
        swp_col_d = swp_col_q;
        swp_lin_d = swp_lin_q;
        advance_c = 1'b0;
        we_c      = 1'b0;
        waddr_c   = {swp_lin_q, swp_col_q};
        wdata_c   = {CHR_BLANK, CLEAR_ATTR};
        accept_c  = char_valid_i & ready_q;

        case (state_q)
            ST_CLEAR: begin
                we_c = 1'b1;
                if (swp_col_q == COL_LAST) begin
                    swp_col_d = '0;
                    if (swp_lin_q == LIN_LAST) begin
                        swp_lin_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        swp_lin_d = swp_lin_q + LW'(1);
                    end
                end else begin
                    swp_col_d = swp_col_q + CW'(1);
                end
            end

            ST_CLRLINE: begin
                we_c = 1'b1;
                if (swp_col_q == COL_LAST) begin
                    swp_col_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    swp_col_d = swp_col_q + CW'(1);
                end
            end

            ST_IDLE: begin
                if (accept_c) begin
                    if ((char_i >= CHR_BLANK) && (char_i <= CHR_TILDE)) begin
                        we_c    = 1'b1;
                        waddr_c = {cur_lin_q, cur_col_q};
                        wdata_c = {char_i, attr_i};
                        if (cur_col_q == COL_LAST) begin
                            cur_col_d = '0;
                            advance_c = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + CW'(1);
                        end
                    end else begin
                        case (char_i)
                            CHR_CR: cur_col_d = '0;
                            CHR_LF: advance_c = 1'b1;
                            CHR_BS: begin
                                if (cur_col_q != '0) begin
                                    cur_col_d = cur_col_q - CW'(1);
                                end
                            end
                            CHR_FF: begin
                                cur_col_d = '0;
                                cur_lin_d = '0;
                                swp_col_d = '0;
                                swp_lin_d = '0;
                                state_d   = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end

                    // Line advance wraps to the top and blanks the line it lands on
                    if (advance_c) begin
                        cur_lin_d = (cur_lin_q == LIN_LAST) ? '0 : cur_lin_q + LW'(1);
                        swp_lin_d = cur_lin_d;
                        swp_col_d = '0;
                        state_d   = ST_CLRLINE;
                    end
                end
            end

            default: begin
                swp_col_d = '0;
                swp_lin_d = '0;
                state_d   = ST_CLEAR;
            end
        endcase
    end

    // Control registers; ready/busy are decoded from the next state so they stay registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            cur_col_q <= '0;
            cur_lin_q <= '0;
            swp_col_q <= '0;
            swp_lin_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cur_col_q <= cur_col_d;
            cur_lin_q <= cur_lin_d;
            swp_col_q <= swp_col_d;
            swp_lin_q <= swp_lin_d;
            ready_q   <= (state_d == ST_IDLE);
            busy_q    <= (state_d == ST_CLEAR);
        end
    end

    // Cell RAM write port; no writes land while reset is asserted
    always_ff @(posedge clk_i) begin
        if (we_c && !rst_i) begin
            mem[waddr_c] <= wdata_c;
        end
    end

    // Display read port; non-blocking update gives read-first on an address collision
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{rd_lin_i, rd_col_i}];
        end
    end

    assign char_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign cursor_col_o = cur_col_q;
    assign cursor_lin_o = cur_lin_q;
    assign chr_o        = rd_data_q[15:8];
    assign rgbifront_o  = rd_data_q[7:4];
    assign rgbiback_o   = rd_data_q[3:0];

endmodule

// File: tb/tb_text_term.sv
// tb_text_term: self-checking bench for text_term.
// It applies a cursor table, hand-written sweep and reset sequences, and checks
// display reads against a cell model through an expected-value queue.
module tb_text_term;

    localparam int COLS  = 30;
    localparam int LINES = 17;
    localparam logic [15:0] BLANK = 16'h2007;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] char_i;
    logic [7:0] attr_i;
    logic       char_valid_i;
    logic       char_ready_o;
    logic [4:0] rd_col_i;
    logic [4:0] rd_lin_i;
    logic [7:0] chr_o;
    logic [3:0] rgbifront_o;
    logic [3:0] rgbiback_o;
    logic [4:0] cursor_col_o;
    logic [4:0] cursor_lin_o;
    logic       busy_o;

    always #5 clk = ~clk;

    text_term #(
        .COLS      (COLS),
        .LINES     (LINES),
        .CLEAR_ATTR(8'h07)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .char_i      (char_i),
        .attr_i      (attr_i),
        .char_valid_i(char_valid_i),
        .char_ready_o(char_ready_o),
        .rd_col_i    (rd_col_i),
        .rd_lin_i    (rd_lin_i),
        .chr_o       (chr_o),
        .rgbifront_o (rgbifront_o),
        .rgbiback_o  (rgbiback_o),
        .cursor_col_o(cursor_col_o),
        .cursor_lin_o(cursor_lin_o),
        .busy_o      (busy_o)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mdl [1024];
    int mcol;
    int mlin;

    typedef struct {
        logic [15:0] data;
        int          col;
        int          lin;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    typedef struct {
        logic [7:0] c;
        logic [7:0] a;
        int         ecol;
        int         elin;
    } vec_t;
    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear_line(input int l);
        for (int c = 0; c < COLS; c++) mdl[l*32+c] = BLANK;
    endtask

    task automatic model_clear_all();
        for (int l = 0; l < LINES; l++) model_clear_line(l);
        mcol = 0;
        mlin = 0;
    endtask

    task automatic model_advance();
        mlin = (mlin == LINES - 1) ? 0 : mlin + 1;
        model_clear_line(mlin);
    endtask

    task automatic model_byte(input logic [7:0] c, input logic [7:0] a);
        if (c >= 8'h20 && c <= 8'h7E) begin
            mdl[mlin*32+mcol] = {c, a};
            if (mcol == COLS - 1) begin
                mcol = 0;
                model_advance();
            end else begin
                mcol++;
            end
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h0A) begin
            model_advance();
        end else if (c == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (c == 8'h0C) begin
            model_clear_all();
        end
    endtask

    task automatic wait_ready();
        int b = 0;
        while (!char_ready_o && b < 2000) begin
            tick();
            b++;
        end
        if (!char_ready_o) chk("ready_timeout", 32'(char_ready_o), 32'd1);
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        wait_ready();
        char_i       = c;
        attr_i       = a;
        char_valid_i = 1'b1;
        tick();
        char_valid_i = 1'b0;
        model_byte(c, a);
    endtask

    task automatic count_ready_low(output int n);
        n = 0;
        while (!char_ready_o && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic count_busy_high(output int n);
        n = 0;
        while (busy_o && n < 2000) begin
            n++;
            tick();
        end
    endtask

    // Expected cell pushed when the address is driven, popped once the read data is out
    task automatic check_read(input int col, input int lin);
        rd_exp_t e;
        wait_ready();
        rd_col_i = 5'(col);
        rd_lin_i = 5'(lin);
        exp_q.push_back('{mdl[lin*32+col], col, lin});
        tick();
        e = exp_q.pop_front();
        chk($sformatf("cell(%0d,%0d)", e.col, e.lin), 32'({chr_o, rgbifront_o, rgbiback_o}), 32'(e.data));
    endtask

    task automatic check_line(input int lin);
        for (int c = 0; c < COLS; c++) check_read(c, lin);
    endtask

    task automatic check_cursor(input string name);
        chk({name, "_col"}, 32'(cursor_col_o), 32'(mcol));
        chk({name, "_lin"}, 32'(cursor_lin_o), 32'(mlin));
    endtask

    initial begin
        int n;

        tbl[0]  = '{8'h43, 8'h2E, 3, 0};
        tbl[1]  = '{8'h08, 8'h00, 2, 0};
        tbl[2]  = '{8'h0D, 8'h00, 0, 0};
        tbl[3]  = '{8'h08, 8'h00, 0, 0};
        tbl[4]  = '{8'h01, 8'h00, 0, 0};
        tbl[5]  = '{8'h7E, 8'h5A, 1, 0};
        tbl[6]  = '{8'h7F, 8'h00, 1, 0};
        tbl[7]  = '{8'h1F, 8'h00, 1, 0};
        tbl[8]  = '{8'h0A, 8'h00, 1, 1};
        tbl[9]  = '{8'h20, 8'h13, 2, 1};
        tbl[10] = '{8'h80, 8'hFF, 2, 1};

        rst_i        = 1'b1;
        char_i       = 8'h00;
        attr_i       = 8'h00;
        char_valid_i = 1'b0;
        rd_col_i     = 5'd0;
        rd_lin_i     = 5'd0;
        mcol         = 0;
        mlin         = 0;
        repeat (3) tick();

        // Reset values
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_ready", 32'(char_ready_o), 32'd0);
        chk("rst_rd", 32'({chr_o, rgbifront_o, rgbiback_o}), 32'd0);
        chk("rst_cur_col", 32'(cursor_col_o), 32'd0);
        chk("rst_cur_lin", 32'(cursor_lin_o), 32'd0);

        // Post-reset clear sweep length
        rst_i = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_o && n < 2000);
        chk("reset_clear_cycles", 32'(n), 32'd510);
        chk("ready_after_clear", 32'(char_ready_o), 32'd1);
        model_clear_all();
        check_read(5, 3);

        // Out-of-range read has no side effects
        rd_col_i = 5'd31;
        rd_lin_i = 5'd31;
        tick();
        chk("oor_ready", 32'(char_ready_o), 32'd1);
        check_cursor("oor");

        // Two printables back-to-back, one per cycle
        chk("A_ready", 32'(char_ready_o), 32'd1);
        char_i = 8'h41; attr_i = 8'h2E; char_valid_i = 1'b1;
        tick();
        chk("B_ready", 32'(char_ready_o), 32'd1);
        char_i = 8'h42;
        tick();
        char_valid_i = 1'b0;
        model_byte(8'h41, 8'h2E);
        model_byte(8'h42, 8'h2E);
        check_cursor("AB");
        check_read(0, 0);
        check_read(1, 0);

        // Cursor table
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].c, tbl[i].a);
            chk($sformatf("tbl%0d_col", i), 32'(cursor_col_o), 32'(tbl[i].ecol));
            chk($sformatf("tbl%0d_lin", i), 32'(cursor_lin_o), 32'(tbl[i].elin));
        end
        check_read(0, 0);
        check_read(2, 0);
        check_read(1, 1);

        // Form feed with a byte held pending during the sweep
        send(8'h0C, 8'h00);
        char_i = 8'h5A; attr_i = 8'h77; char_valid_i = 1'b1;
        count_busy_high(n);
        char_valid_i = 1'b0;
        chk("ff_busy_cycles", 32'(n), 32'd510);
        check_cursor("ff");
        check_line(0);
        check_line(1);

        // Backspace at column 0
        send(8'h08, 8'h00);
        check_cursor("bs_col0");

        // Fill line 0, walk down to line 16, then wrap with 30 printables
        for (int i = 0; i < 5; i++) send(8'h48 + 8'(i), 8'h4C);
        send(8'h0D, 8'h00);
        for (int i = 0; i < 16; i++) send(8'h0A, 8'h00);
        check_cursor("at_lin16");
        for (int i = 0; i < COLS; i++) send(8'h30 + 8'(i % 10), 8'h1F);
        count_ready_low(n);
        chk("wrap_ready_low", 32'(n), 32'd30);
        check_cursor("wrap");
        check_line(0);
        check_line(16);

        // LF from (7,16) wraps to line 0 and clears only that line
        for (int i = 0; i < 7; i++) send(8'h61 + 8'(i), 8'h61);
        for (int i = 0; i < 16; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 3; i++) send(8'h58 + 8'(i), 8'hC3);
        for (int i = 0; i < 3; i++) send(8'h08, 8'h00);
        check_cursor("at_7_16");
        send(8'h0A, 8'h00);
        count_ready_low(n);
        chk("lf_ready_low", 32'(n), 32'd30);
        check_cursor("lf_wrap");
        check_line(0);
        check_line(16);
        check_read(4, 8);

        // Reset pulse in the middle of a line clear
        send(8'h0A, 8'h00);
        repeat (10) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        model_clear_all();
        check_cursor("rst_mid");
        count_busy_high(n);
        chk("rst_mid_busy_cycles", 32'(n), 32'd510);
        check_line(0);
        check_line(1);
        check_read(9, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
